// File: rtl/whac_a_mole_pkg.sv
// Shared types and helpers for the multi-mole whac-a-mole controller.
package whac_a_mole_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StPlay = 2'd1,
    StOver = 2'd2
  } game_state_e;

  localparam logic [7:0] LevelBaseEasy = 8'd1;
  localparam logic [7:0] LevelBaseMed  = 8'd3;
  localparam logic [7:0] LevelBaseHard = 8'd5;

  function automatic logic [7:0] level_base(input logic [1:0] lvl);
    if (lvl == 2'd0) return LevelBaseEasy;
    if (lvl == 2'd1) return LevelBaseMed;
    return LevelBaseHard;
  endfunction

  function automatic int unsigned max_moles_for_level(input logic [1:0]  lvl,
                                                      input int unsigned max_moles);
    if (lvl == 2'd0) return 1;
    if (lvl == 2'd1) return (max_moles < 2) ? max_moles : 2;
    return max_moles;
  endfunction

  function automatic int unsigned hole_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mole_slot.sv
// One mole slot: holds the occupied hole and its countdown, flags hit or expiry.
module mole_slot
  import whac_a_mole_pkg::*;
#(
  parameter int unsigned NUM_HOLES = 18,
  parameter int unsigned TIMER_W   = 16,
  parameter int unsigned HOLE_W    = hole_w(NUM_HOLES)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [HOLE_W-1:0]    load_hole,
  input  logic [TIMER_W-1:0]   load_time,
  input  logic                 tick,
  input  logic                 clear,
  input  logic [NUM_HOLES-1:0] switches,
  output logic                 active,
  output logic [HOLE_W-1:0]    hole,
  output logic [TIMER_W-1:0]   timer,
  output logic                 hit_req,
  output logic                 miss_req
);

  localparam int unsigned PadW = 1 << HOLE_W;

  logic [PadW-1:0] sw_pad;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      active <= 1'b0;
      hole   <= '0;
      timer  <= '0;
    end else if (load) begin
      active <= 1'b1;
      hole   <= load_hole;
      timer  <= (load_time == '0) ? TIMER_W'(1) : load_time;
    end else if (tick && active && (timer != '0)) begin
      timer <= timer - TIMER_W'(1);
    end
  end

  always_comb begin
    sw_pad   = PadW'(switches);
    hit_req  = active && sw_pad[hole];
    // A hit on an expired mole still counts as a hit.
    miss_req = active && (timer == '0) && !hit_req;
  end

endmodule

// File: rtl/whac_a_mole_multi_fsm.sv
// Multi-mole game controller: spawn arbitration, hit/miss priority, scoring and game state.
module whac_a_mole_multi_fsm
  import whac_a_mole_pkg::*;
#(
  parameter int unsigned NUM_HOLES   = 18,
  parameter int unsigned MAX_MOLES   = 3,
  parameter int unsigned LIVES       = 3,
  parameter int unsigned POINT_W     = 16,
  parameter int unsigned TIMER_W     = 16,
  parameter int unsigned BASE_POINTS = 10,
  parameter int unsigned COMBO_STEP  = 5,
  parameter int unsigned BONUS_SHIFT = 7
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start_button,
  input  logic                            abort_button,
  input  logic [1:0]                      level,
  input  logic                            tick,
  input  logic [TIMER_W-1:0]              mole_time,
  input  logic                            rng_valid,
  input  logic [hole_w(NUM_HOLES)-1:0]    rng_index,
  output logic                            rng_ready,
  input  logic [NUM_HOLES-1:0]            switches,
  output logic [NUM_HOLES-1:0]            mole_leds,
  output logic [POINT_W-1:0]              points,
  output logic [$clog2(LIVES+1)-1:0]      lives_left,
  output logic [7:0]                      combo,
  output logic                            game_over,
  output logic [1:0]                      state
);

  localparam int unsigned HoleW  = hole_w(NUM_HOLES);
  localparam int unsigned LivesW = $clog2(LIVES + 1);
  localparam int unsigned MultW  = 9;
  localparam int unsigned GainW  = POINT_W + TIMER_W + MultW + 8;

  game_state_e         state_q;
  logic [1:0]          level_q;
  logic                start_q, abort_q;
  logic [POINT_W-1:0]  points_q;
  logic [LivesW-1:0]   lives_q;
  logic [7:0]          combo_q;
  logic                game_over_q;

  logic                start_edge, abort_edge, in_play;
  logic [MAX_MOLES-1:0] slot_active, slot_hit, slot_miss;
  logic [MAX_MOLES-1:0] load_sel, slot_load, hit_sel, miss_sel, slot_clear;
  logic [HoleW-1:0]     slot_hole [MAX_MOLES];
  logic [TIMER_W-1:0]   slot_timer [MAX_MOLES];

  int unsigned          active_count;
  logic                 free_found, dup, in_range, spawn_ok;
  logic                 hit_any, miss_any, clear_all;
  logic [TIMER_W-1:0]   hit_timer;
  logic [MultW-1:0]     mult;
  logic [GainW-1:0]     gain, sum;
  logic [POINT_W-1:0]   points_hit;

  assign start_edge = start_button && !start_q;
  assign abort_edge = abort_button && !abort_q;
  assign in_play    = (state_q == StPlay);

  for (genvar g = 0; g < MAX_MOLES; g++) begin : gen_slot
    mole_slot #(
      .NUM_HOLES (NUM_HOLES),
      .TIMER_W   (TIMER_W),
      .HOLE_W    (HoleW)
    ) u_slot (
      .clk       (clk),
      .reset     (reset),
      .load      (slot_load[g]),
      .load_hole (rng_index),
      .load_time (mole_time),
      .tick      (tick),
      .clear     (slot_clear[g]),
      .switches  (switches),
      .active    (slot_active[g]),
      .hole      (slot_hole[g]),
      .timer     (slot_timer[g]),
      .hit_req   (slot_hit[g]),
      .miss_req  (slot_miss[g])
    );
  end

  // Spawn arbitration and lowest-index-first hit/miss selection.
  always_comb begin
    active_count = 0;
    free_found   = 1'b0;
    dup          = 1'b0;
    load_sel     = '0;
    hit_sel      = '0;
    miss_sel     = '0;
    hit_any      = 1'b0;
    miss_any     = 1'b0;
    hit_timer    = '0;
    for (int i = 0; i < MAX_MOLES; i++) begin
      active_count = active_count + 32'(slot_active[i]);
      if (slot_active[i] && (slot_hole[i] == rng_index)) dup = 1'b1;
      if (!slot_active[i] && !free_found) begin
        load_sel[i] = 1'b1;
        free_found  = 1'b1;
      end
      if (in_play && slot_hit[i] && !hit_any) begin
        hit_sel[i] = 1'b1;
        hit_any    = 1'b1;
        hit_timer  = slot_timer[i];
      end
      if (in_play && slot_miss[i] && !miss_any) begin
        miss_sel[i] = 1'b1;
        miss_any    = 1'b1;
      end
    end
    rng_ready = in_play && (active_count < max_moles_for_level(level_q, MAX_MOLES));
    in_range  = (32'(rng_index) < NUM_HOLES);
    spawn_ok  = rng_valid && rng_ready && in_range && !dup;
    slot_load = spawn_ok ? load_sel : '0;

    clear_all = (in_play && (abort_edge || (miss_any && (lives_q <= LivesW'(1))))) ||
                (!in_play && start_edge && !abort_edge);
    slot_clear = hit_sel | miss_sel | {MAX_MOLES{clear_all}};
  end

  always_comb begin
    mult = MultW'(level_base(level_q)) + MultW'(combo_q / 8'(COMBO_STEP));
    gain = GainW'(mult) * GainW'(BASE_POINTS) + GainW'(mult) * GainW'(hit_timer >> BONUS_SHIFT);
    sum  = GainW'(points_q) + gain;
    points_hit = (sum[GainW-1:POINT_W] != '0) ? '1 : sum[POINT_W-1:0];
  end

  always_comb begin
    mole_leds = '0;
    for (int h = 0; h < NUM_HOLES; h++) begin
      for (int i = 0; i < MAX_MOLES; i++) begin
        if (slot_active[i] && (slot_hole[i] == HoleW'(h))) mole_leds[h] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      level_q     <= 2'd0;
      start_q     <= 1'b0;
      abort_q     <= 1'b0;
      points_q    <= '0;
      lives_q     <= LivesW'(LIVES);
      combo_q     <= '0;
      game_over_q <= 1'b0;
    end else begin
      start_q <= start_button;
      abort_q <= abort_button;
      unique case (state_q)
        StIdle, StOver: begin
          if (abort_edge) begin
            state_q     <= StIdle;
            game_over_q <= 1'b0;
          end else if (start_edge) begin
            state_q     <= StPlay;
            game_over_q <= 1'b0;
            points_q    <= '0;
            combo_q     <= '0;
            lives_q     <= LivesW'(LIVES);
            level_q     <= (level == 2'd3) ? 2'd2 : level;
          end
        end
        StPlay: begin
          if (abort_edge) begin
            state_q <= StIdle;
          end else begin
            if (hit_any) begin
              points_q <= points_hit;
              combo_q  <= (combo_q == 8'hFF) ? combo_q : combo_q + 8'd1;
            end
            if (miss_any) begin
              combo_q <= '0;
              if (lives_q != '0) lives_q <= lives_q - LivesW'(1);
              if (lives_q <= LivesW'(1)) begin
                state_q     <= StOver;
                game_over_q <= 1'b1;
              end
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign points     = points_q;
  assign lives_left = lives_q;
  assign combo      = combo_q;
  assign game_over  = game_over_q;
  assign state      = state_q;

endmodule

// File: doc/whac_a_mole_multi_fsm.md
Name: whac_a_mole_multi_fsm

Overview:
Parametrised successor to the single-mole game controller.
- Runs up to MAX_MOLES concurrent moles over NUM_HOLES holes, each with its own countdown.
- Tracks lives, a hit-streak combo multiplier and a time bonus; the game ends when lives reach zero.
- Sits between the RNG (valid/ready handshake), the switch inputs, the LED driver and the score/seven-seg display.

Parameters:
NUM_HOLES, 18, number of holes / switches / LEDs
MAX_MOLES, 3, number of mole slots (concurrent moles at the hardest level)
LIVES, 3, lives at game start
POINT_W, 16, score width
TIMER_W, 16, per-mole countdown width
BASE_POINTS, 10, points per hit before multiplier
COMBO_STEP, 5, consecutive hits per +1 multiplier
BONUS_SHIFT, 7, bonus = remaining_time >> BONUS_SHIFT

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start_button  in  1  raw level; rising edge detected internally
abort_button  in  1  raw level; rising edge detected internally
level  in  2  0=easy, 1=medium, 2=hard (3 treated as 2); sampled on start
tick  in  1  1-cycle timebase strobe (e.g. 1 ms)
mole_time  in  TIMER_W  countdown load value in ticks, sampled per spawn
rng_valid  in  1  rng_index valid
rng_index  in  $clog2(NUM_HOLES)  candidate hole
rng_ready  out  1  block accepts a spawn this cycle
switches  in  NUM_HOLES  toggle switch levels
mole_leds  out  NUM_HOLES  one-hot-per-active-mole LED mask
points  out  POINT_W  score
lives_left  out  $clog2(LIVES+1)  remaining lives
combo  out  8  current consecutive-hit count, saturating at 255
game_over  out  1  high in OVER state
state  out  2  IDLE=0, PLAY=1, OVER=2

Behaviour:
- Reset values: state=IDLE, all slots inactive, mole_leds=0, points=0, lives_left=LIVES, combo=0, rng_ready=0, game_over=0. Edge-detect registers are cleared.
- **IDLE**
  - On start edge: points=0, combo=0, lives_left=LIVES, latch level, go to PLAY.
  - Points are held in IDLE from any previous game until the next start.
- **PLAY, spawn**
  - Active-mole limit: level 0 → 1, level 1 → min(2, MAX_MOLES), level 2 → MAX_MOLES.
  - rng_ready=1 when the active count is below the limit.
  - On rng_valid && rng_ready:
    - If rng_index ≥ NUM_HOLES or that hole is already active, discard; no spawn.
    - Otherwise, the lowest-index free slot gets hole=rng_index and timer=mole_time.
    - The LED is on the next cycle.
    - A mole_time of 0 is loaded as 1.
- **PLAY, hit**
  - A slot is hit when it is active and switches[hole]=1; the check is level-sensitive.
  - At most one hit per cycle, lowest-index slot first; remaining hits resolve on later cycles.
  - On a hit, in the next cycle:
    - the slot clears;
    - combo increments (saturating);
    - mult = level_base + combo_before/COMBO_STEP, with level_base 1/3/5;
    - points += mult*BASE_POINTS + mult*(timer>>BONUS_SHIFT).
  - Points saturate at 2^POINT_W−1.
- **PLAY, timers and miss**
  - On tick, each active slot with timer>0 decrements.
  - An active slot with timer==0 is a miss.
  - At most one miss per cycle, lowest index first.
  - On a miss: the slot clears, combo=0, lives_left decrements (never below 0).
  - Hit and miss on the same slot in the same cycle: the hit wins.
  - A hit and a miss on different slots in the same cycle are both processed.
- **Exits from PLAY**
  - lives_left reaching 0 → OVER on the next cycle; all slots clear and rng_ready=0.
  - Abort edge in PLAY → IDLE; slots clear, points held.
- **OVER**
  - mole_leds=0 and points frozen.
  - A start edge starts a new game, exactly as from IDLE.
  - An abort edge goes to IDLE.
- Start and abort edges in the same cycle: abort wins.
- Reset asserted mid-game returns every register to its reset value on the next edge.

Decomposition:
- Package whac_a_mole_pkg holds:
  - the state enum (IDLE/PLAY/OVER);
  - the level_base constants 1/3/5;
  - the level-to-max-moles function;
  - the hole index width function.
- Sub-module mole_slot, instantiated MAX_MOLES times. It holds active, hole and timer, and provides:
  - load;
  - tick decrement;
  - clear;
  - hit_req / miss_req outputs.
- The top level does priority selection, scoring and state.

Test Plan:
1. Level 0, mole_time=100, spawn hole 4, set switches[4] after 20 ticks → mole_leds[4] clears; points=10+1*(80>>7)=10; combo=1.
2. Level 2, 6 consecutive hits with timer ≥128 remaining → the 6th hit scores mult=6: 60+6=66; combo=6.
3. Three spawns at level 1, never hit → rng_ready drops once 2 moles are active; each expiry decrements lives; after 3 misses state=OVER, game_over=1, mole_leds=0.
4. Spawn hole 7, then rng_index=7 again → second spawn discarded, only one slot active; rng_index=20 (NUM_HOLES=18) → discarded.
5. Two moles on holes 2 and 9, both switches set in the same cycle → two hits on consecutive cycles; points accumulate correctly.
6. Abort mid-PLAY with points=40 → state=IDLE, LEDs off, points=40; start → points=0, lives=3. Reset mid-PLAY → all outputs at reset values.
